vga_dither_out: RTL and testbench
=================================

# vga_dither_out

Parametrised VGA colour output stage between the video core's IN_W-bit RGB pixel stream and the board's narrower resistor DAC pins. It replaces plain MSB truncation with selectable truncate, round or ordered-dither (spatial, or spatial plus temporal) reduction. It also tracks pixel position from DE and sync, and delays HSYNC/VSYNC to match the pixel pipeline. One instance sits at the top level between the system core and the VGA pins.

## Interface
- IN_W, 6, input component width per colour
- OUT_W, 3, output component width per colour; D = IN_W-OUT_W, legal range 1..4
- SYNC_ACTIVE, 0, active level of in/out hsync and vsync (0 = active-low)
- clk_vga  in  1  pixel clock
- reset  in  1  synchronous, active-high
- in_r, in_g, in_b  in  IN_W each  pixel components
- in_de  in  1  1 = active video pixel
- in_hsync, in_vsync  in  1 each  syncs, level SYNC_ACTIVE when asserted
- mode  in  2  0 truncate, 1 round, 2 ordered dither, 3 ordered + temporal dither
- out_r, out_g, out_b  out  OUT_W each  reduced components
- out_hsync, out_vsync  out  1 each  syncs delayed to align with pixels

## Operation
- Position tracking:
  - x (≥12 bits) increments on each in_de=1 cycle and clears on the in_de 1→0 edge.
  - y (≥11 bits) increments on the in_de 1→0 edge and clears on the vsync assertion edge (in_vsync becomes SYNC_ACTIVE).
  - Only x[1:0] and y[1:0] are used. Wrap is harmless.
- Frame counter f: 2 bits, increments on the vsync assertion edge and wraps 3→0.
- Mode latch: mode_q loads mode on the vsync assertion edge only. Changing mode mid-frame takes effect from the next frame.
- Bayer matrix B[row][col]:
  - row0: 0 8 2 10
  - row1: 12 4 14 6
  - row2: 3 11 1 9
  - row3: 15 7 13 5
- Threshold t per mode_q:
  - 0: t = 0
  - 1: t = 1<<(D-1)
  - 2: t = B[y[1:0]][x[1:0]] >> (4-D)
  - 3: as mode 2 but with column index (x[1:0]+f) mod 4 and row index (y[1:0]+f) mod 4
  - The same t applies to R, G and B.
- Arithmetic: s = in + t in IN_W+1 bits. If s ≥ 2^IN_W, out = all ones (saturate); else out = s[IN_W-1:D].
- Blanking: when the pixel's in_de = 0, out_r/g/b = 0, regardless of mode.
- Syncs pass through unmodified apart from delay. No polarity change.

## Timing
- Two-stage pipeline.
  - Stage 1 registers the inputs, de, the syncs and t.
  - Stage 2 performs the add, saturate, shift and blank.
- Inputs at edge N appear on all outputs at edge N+2. Pixel, DE-blank and sync latencies are identical.
- The position used for a pixel is the count before that pixel's own increment, so the first active pixel of a line has x=0.
- Simultaneous events:
  - The de falling edge and vsync assertion in the same cycle: y clears (clear wins over increment); f increments.
  - mode changing on the vsync-edge cycle: the new value is captured.
- Reset state:
  - out_r/g/b = 0; out_hsync = out_vsync = ~SYNC_ACTIVE.
  - x, y, f, mode_q = 0; pipeline registers at the same inactive values.
- Reset applies mid-frame with no recovery: the next frame realigns counters at vsync. Until then, dither indices count from 0.
- No backpressure: one pixel accepted every clock. No enable input.

## Test plan
- Reset: assert reset 3 cycles mid-line with in_de=1 → outputs 0, syncs = ~SYNC_ACTIVE, then normal 2-cycle latency from release.
- Truncate (mode 0, IN_W=6, OUT_W=3): in_r=45, in_g=63, in_b=7 → out 5, 7, 0, two clocks later; hsync pulse emerges two clocks later with unchanged width.
- Round (mode 1): in_r=45 → 6; in_r=63 → 7 (saturated); in_r=3 → 0; in_r=4 → 1.
- Ordered (mode 2): constant in_r=44 across a line on y=0 → out_r sequence 5,6,5,6 repeating; on line y=1 (thresholds 6,2,7,3) → 6,5,6,5.
- Temporal (mode 3): same stimulus over four frames → line y=0 pattern phase-shifts per frame per the index rule; the frame-0 pattern matches mode 2.
- Blank and mode latch:
  - in_de=0 with in_r=63 → out 0.
  - Switch mode 0→2 mid-frame → output stays truncated until after the next vsync assertion, then dithers.

Source files
------------

// File: rtl/vga_dither_out.sv
// VGA colour output stage: reduces IN_W-bit RGB to OUT_W bits by truncate, round
// or ordered/temporal dither, with syncs delayed to stay aligned with the pixels.
module vga_dither_out #(
  parameter int IN_W        = 6,
  parameter int OUT_W       = 3,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_r,
  input  logic [IN_W-1:0]  in_g,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] out_r,
  output logic [OUT_W-1:0] out_g,
  output logic [OUT_W-1:0] out_b,
  output logic             out_hsync,
  output logic             out_vsync
);

  localparam int D         = IN_W - OUT_W;
  localparam bit SYNC_IDLE = ~SYNC_ACTIVE;

  localparam logic [1:0] MODE_TRUNC    = 2'd0;
  localparam logic [1:0] MODE_ROUND    = 2'd1;
  localparam logic [1:0] MODE_ORDERED  = 2'd2;
  localparam logic [1:0] MODE_TEMPORAL = 2'd3;

  logic [11:0] x_cnt;
  logic [10:0] y_cnt;
  logic [1:0]  frame_cnt;
  logic [1:0]  mode_q;
  logic        de_prev;
  logic        vsync_prev;
  logic        vs_edge;
  logic        de_fall;

  // Only the low two position bits index the matrix; the rest just keep counting.
  logic unused_pos;
  assign unused_pos = ^{x_cnt[11:2], y_cnt[10:2]};

  assign vs_edge = (in_vsync == SYNC_ACTIVE) && (vsync_prev != SYNC_ACTIVE);
  assign de_fall = !in_de && de_prev;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_cnt  <= '0;
      mode_q     <= MODE_TRUNC;
      de_prev    <= 1'b0;
      vsync_prev <= SYNC_IDLE;
    end else begin
      de_prev    <= in_de;
      vsync_prev <= in_vsync;

      if (de_fall)
        x_cnt <= '0;
      else if (in_de)
        x_cnt <= x_cnt + 12'd1;

      // A vsync edge coinciding with the end of a line must still leave y at 0.
      if (vs_edge)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= y_cnt + 11'd1;

      if (vs_edge) begin
        frame_cnt <= frame_cnt + 2'd1;
        mode_q    <= mode;
      end
    end
  end

  function automatic logic [3:0] bayer4(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] val;
    case ({row, col})
      4'h0: val = 4'd0;
      4'h1: val = 4'd8;
      4'h2: val = 4'd2;
      4'h3: val = 4'd10;
      4'h4: val = 4'd12;
      4'h5: val = 4'd4;
      4'h6: val = 4'd14;
      4'h7: val = 4'd6;
      4'h8: val = 4'd3;
      4'h9: val = 4'd11;
      4'hA: val = 4'd1;
      4'hB: val = 4'd9;
      4'hC: val = 4'd15;
      4'hD: val = 4'd7;
      4'hE: val = 4'd13;
      default: val = 4'd5;
    endcase
    return val;
  endfunction

  logic [1:0]   row_idx;
  logic [1:0]   col_idx;
  logic [3:0]   bayer_val;
  logic [3:0]   bayer_shift;
  logic [D-1:0] t_next;

  always_comb begin
    row_idx = y_cnt[1:0];
    col_idx = x_cnt[1:0];
    if (mode_q == MODE_TEMPORAL) begin
      row_idx = y_cnt[1:0] + frame_cnt;
      col_idx = x_cnt[1:0] + frame_cnt;
    end
    bayer_val   = bayer4(row_idx, col_idx);
    bayer_shift = bayer_val >> (4 - D);

    t_next = '0;
    case (mode_q)
      MODE_ROUND:    t_next[D-1] = 1'b1;
      MODE_ORDERED,
      MODE_TEMPORAL: t_next = bayer_shift[D-1:0];
      default:       t_next = '0;
    endcase
  end

  logic [IN_W-1:0] r_s1;
  logic [IN_W-1:0] g_s1;
  logic [IN_W-1:0] b_s1;
  logic            de_s1;
  logic            hs_s1;
  logic            vs_s1;
  logic [D-1:0]    t_s1;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_s1  <= '0;
      g_s1  <= '0;
      b_s1  <= '0;
      de_s1 <= 1'b0;
      hs_s1 <= SYNC_IDLE;
      vs_s1 <= SYNC_IDLE;
      t_s1  <= '0;
    end else begin
      r_s1  <= in_r;
      g_s1  <= in_g;
      b_s1  <= in_b;
      de_s1 <= in_de;
      hs_s1 <= in_hsync;
      vs_s1 <= in_vsync;
      t_s1  <= t_next;
    end
  end

  // Add threshold one bit wider than the input so overflow shows up as saturation.
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] comp,
                                              input logic [D-1:0]    thr);
    logic [IN_W:0] sum;
    sum = {1'b0, comp} + {{(IN_W + 1 - D){1'b0}}, thr};
    if (sum[IN_W])
      return '1;
    else
      return sum[IN_W-1:D];
  endfunction

  logic [OUT_W-1:0] r_red;
  logic [OUT_W-1:0] g_red;
  logic [OUT_W-1:0] b_red;

  always_comb begin
    r_red = '0;
    g_red = '0;
    b_red = '0;
    if (de_s1) begin
      r_red = reduce(r_s1, t_s1);
      g_red = reduce(g_s1, t_s1);
      b_red = reduce(b_s1, t_s1);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_hsync <= SYNC_IDLE;
      out_vsync <= SYNC_IDLE;
    end else begin
      out_r     <= r_red;
      out_g     <= g_red;
      out_b     <= b_red;
      out_hsync <= hs_s1;
      out_vsync <= vs_s1;
    end
  end

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out: a behavioural position/threshold model
// predicts each pixel, and results are compared two clocks after driving.
module tb_vga_dither_out;
  localparam int IN_W  = 6;
  localparam int OUT_W = 3;
  localparam int D     = IN_W - OUT_W;
  localparam int MAXO  = (1 << OUT_W) - 1;
  localparam int SA    = 0;
  localparam int SI    = 1 - SA;

  logic             clk_vga = 1'b0;
  logic             reset   = 1'b1;
  logic [IN_W-1:0]  in_r = '0, in_g = '0, in_b = '0;
  logic             in_de = 1'b0;
  logic             in_hsync = 1'b1, in_vsync = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic [OUT_W-1:0] out_r, out_g, out_b;
  logic             out_hsync, out_vsync;

  vga_dither_out #(.IN_W(IN_W), .OUT_W(OUT_W), .SYNC_ACTIVE(1'b0)) dut (
    .clk_vga(clk_vga), .reset(reset),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync), .mode(mode),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct { int r; int g; int b; int hs; int vs; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  int mx = 0, my = 0, mf = 0, mmode = 0, mde_prev = 0, mvs_prev = SI;
  int mode_drv = 0;
  int bayer[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int reduce_ref(input int c, input int t);
    int v;
    v = (c + t) >> D;
    return (v > MAXO) ? MAXO : v;
  endfunction

  function automatic int thr_ref();
    int row, col;
    case (mmode)
      1: return 1 << (D - 1);
      2: return bayer[(my % 4) * 4 + (mx % 4)] >> (4 - D);
      3: begin
        row = (my + mf) % 4;
        col = (mx + mf) % 4;
        return bayer[row * 4 + col] >> (4 - D);
      end
      default: return 0;
    endcase
  endfunction

  task automatic step(input int r, input int g, input int b, input int de,
                      input int hs, input int vs, input int rst);
    exp_t e;
    int t;
    bit vs_edge, de_fall;
    @(negedge clk_vga);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check_eq("out_r", int'(out_r), e.r);
      check_eq("out_g", int'(out_g), e.g);
      check_eq("out_b", int'(out_b), e.b);
      check_eq("out_hsync", int'(out_hsync), e.hs);
      check_eq("out_vsync", int'(out_vsync), e.vs);
    end
    in_r = IN_W'(r); in_g = IN_W'(g); in_b = IN_W'(b);
    in_de = de[0]; in_hsync = hs[0]; in_vsync = vs[0];
    mode = 2'(mode_drv);
    reset = rst[0];
    if (rst != 0) begin
      e = '{r: 0, g: 0, b: 0, hs: SI, vs: SI};
      sb.delete();
      sb.push_back(e);
      sb.push_back(e);
      mx = 0; my = 0; mf = 0; mmode = 0; mde_prev = 0; mvs_prev = SI;
    end else begin
      t = thr_ref();
      e.r  = de ? reduce_ref(r, t) : 0;
      e.g  = de ? reduce_ref(g, t) : 0;
      e.b  = de ? reduce_ref(b, t) : 0;
      e.hs = hs;
      e.vs = vs;
      sb.push_back(e);
      vs_edge = (vs == SA) && (mvs_prev != SA);
      de_fall = (de == 0) && (mde_prev == 1);
      if (de_fall) mx = 0; else if (de != 0) mx++;
      if (vs_edge) my = 0; else if (de_fall) my++;
      if (vs_edge) begin
        mf = (mf + 1) % 4;
        mmode = mode_drv;
      end
      mde_prev = de;
      mvs_prev = vs;
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, (1 << IN_W) - 1));
  endfunction

  task automatic idle(input int n);
    repeat (n) step(rnd(), rnd(), rnd(), 0, SI, SI, 0);
  endtask

  task automatic vsync_pulse();
    idle(2);
    repeat (3) step(rnd(), rnd(), rnd(), 0, SI, SA, 0);
    idle(2);
  endtask

  // cr < 0 gives random red; otherwise constant red across the line.
  task automatic hline(input int n, input int cr);
    repeat (3) step(rnd(), rnd(), rnd(), 0, SA, SI, 0);
    idle(2);
    for (int i = 0; i < n; i++)
      step((cr < 0) ? rnd() : cr, rnd(), rnd(), 1, SI, SI, 0);
    idle(2);
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 0, SI, SI, 1);

    // truncate, including the directed 45/63/7 pixel
    mode_drv = 0;
    vsync_pulse();
    hline(4, -1);
    step(45, 63, 7, 1, SI, SI, 0);
    step(63, 63, 63, 0, SI, SI, 0);
    idle(2);
    hline(6, -1);

    // round with saturation and boundary values
    mode_drv = 1;
    vsync_pulse();
    step(45, 63, 3, 1, SI, SI, 0);
    step(4, 3, 63, 1, SI, SI, 0);
    step(60, 59, 0, 1, SI, SI, 0);
    idle(2);
    hline(8, -1);

    // ordered dither: constant 44 over four lines
    mode_drv = 2;
    vsync_pulse();
    for (int l = 0; l < 4; l++) hline(8, 44);
    hline(8, -1);

    // temporal dither over four frames
    mode_drv = 3;
    for (int fr = 0; fr < 4; fr++) begin
      vsync_pulse();
      for (int l = 0; l < 2; l++) hline(8, 44);
    end

    // mode change mid-frame only takes effect after the next vsync
    mode_drv = 0;
    vsync_pulse();
    hline(8, 44);
    mode_drv = 2;
    hline(8, 44);
    hline(8, 44);
    vsync_pulse();
    hline(8, 44);
    hline(8, 44);

    // de falling edge coincident with vsync assertion
    step(20, 21, 22, 1, SI, SI, 0);
    step(rnd(), rnd(), rnd(), 0, SI, SA, 0);
    step(rnd(), rnd(), rnd(), 0, SI, SA, 0);
    idle(2);
    hline(8, 44);

    // reset mid-line with de held high
    repeat (3) step(rnd(), rnd(), rnd(), 1, SI, SI, 0);
    repeat (3) step(63, 63, 63, 1, SI, SI, 1);
    repeat (6) step(44, rnd(), rnd(), 1, SI, SI, 0);
    idle(2);
    hline(8, 44);

    // random frames with random mode
    for (int fr = 0; fr < 4; fr++) begin
      mode_drv = int'($urandom_range(0, 3));
      vsync_pulse();
      for (int l = 0; l < 3; l++) hline(int'($urandom_range(3, 10)), -1);
    end

    idle(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
